// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and constants for the elevator request scheduler.
// State encoding, default floor count, floor index type and sweep direction values.
package elevator_pkg;

   localparam int NUM_FLOORS_DEFAULT = 4;

   typedef logic [$clog2(NUM_FLOORS_DEFAULT)-1:0] floor_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DISPATCH = 3'd1,
      ST_TRAVEL   = 3'd2,
      ST_DOOR     = 3'd3,
      ST_HALT     = 3'd4
   } state_t;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Car-side bus of the scheduler: calls, car status, target handshake and status outputs.
// served_count exists only when SCHED_STATS_EN is defined.
interface elevator_request_scheduler_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
);
   localparam int FW = $clog2(NUM_FLOORS);

   logic                  emergency_stop;
   logic [NUM_FLOORS-1:0] call_req;
   logic [FW-1:0]         current_floor;
   logic                  car_arrived;
   logic                  target_ready;
   logic                  target_valid;
   logic [FW-1:0]         target_floor;
   logic [NUM_FLOORS-1:0] pending;
   logic                  dir_up;
   logic                  door_hold;
   logic                  busy;
`ifdef SCHED_STATS_EN
   logic [15:0]           served_count;
`endif

   modport master (
      input  emergency_stop, call_req, current_floor, car_arrived, target_ready,
      output target_valid, target_floor, pending, dir_up, door_hold, busy
`ifdef SCHED_STATS_EN
      , output served_count
`endif
   );

   modport slave (
      output emergency_stop, call_req, current_floor, car_arrived, target_ready,
      input  target_valid, target_floor, pending, dir_up, door_hold, busy
`ifdef SCHED_STATS_EN
      , input served_count
`endif
   );

endinterface

// File: rtl/elevator_request_scheduler_door_timer.sv
// Door-open down-counter: loads DOOR_CYCLES-1 on start/restart, counts while hold is high.
// done flags terminal count; clear forces the counter to zero.
module elevator_door_timer #(
   parameter int DOOR_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic restart,
   input  logic clear,
   input  logic hold,
   output logic done
);
   localparam logic [7:0] LOAD_VAL = 8'(DOOR_CYCLES - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (clear) begin
         r_count <= 8'd0;
      end else if (start || restart) begin
         r_count <= LOAD_VAL;
      end else if (hold && (r_count != 8'd0)) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign done = (r_count == 8'd0);

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN elevator request scheduler: latches floor calls, offers targets, times door stops.
// Optional SCHED_STATS_EN adds a saturating served_count on the interface.
//
// state    | meaning
// IDLE     | no stop in progress; inspect pending
// DISPATCH | target_floor offered, waiting for target_ready
// TRAVEL   | car moving to target, waiting for car_arrived
// DOOR     | door held open for DOOR_CYCLES cycles
// HALT     | emergency stop active, door held, no target offered
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
   parameter int DOOR_CYCLES = 8
) (
   input logic                          clk,
   input logic                          rst,
   elevator_request_scheduler_if.master bus
);
   localparam int FW = $clog2(NUM_FLOORS);

   state_t                r_state, w_state_next;
   logic [NUM_FLOORS-1:0] r_pending, w_call_mask, w_clear_mask;
   logic [FW-1:0]         r_target_floor, w_cur_floor, w_sel_floor, w_sel_up, w_sel_dn;
   logic                  r_dir_up, r_target_valid, r_door_hold, r_busy;
   logic                  w_sel_dir, w_found_up, w_found_dn, w_handshake, w_load_target;
   logic                  w_tv_next, w_dh_next, w_busy_next;
   logic                  w_door_start, w_door_restart, w_door_clear, w_door_run, w_door_done;
   int                    w_cf_raw, w_cur_idx;

   // Out-of-range positions are treated as the top floor.
   always_comb begin
      w_cf_raw    = int'(bus.current_floor);
      w_cur_idx   = (w_cf_raw >= NUM_FLOORS) ? NUM_FLOORS - 1 : w_cf_raw;
      w_cur_floor = FW'(w_cur_idx);
   end

   always_comb begin
      w_sel_up   = '0;
      w_found_up = 1'b0;
      w_sel_dn   = '0;
      w_found_dn = 1'b0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (r_pending[i] && (i > w_cur_idx)) begin
            w_sel_up   = FW'(i);
            w_found_up = 1'b1;
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (r_pending[i] && (i < w_cur_idx)) begin
            w_sel_dn   = FW'(i);
            w_found_dn = 1'b1;
         end
      end
      if (r_dir_up == DIR_UP) begin
         w_sel_floor = w_found_up ? w_sel_up : w_sel_dn;
         w_sel_dir   = w_found_up ? DIR_UP : DIR_DOWN;
      end else begin
         w_sel_floor = w_found_dn ? w_sel_dn : w_sel_up;
         w_sel_dir   = w_found_dn ? DIR_DOWN : DIR_UP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next   = r_state;
      w_clear_mask   = '0;
      w_call_mask    = '1;
      w_door_start   = 1'b0;
      w_door_restart = 1'b0;
      w_handshake    = r_target_valid && bus.target_ready;
      if (bus.emergency_stop) begin
         w_state_next = ST_HALT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_pending[w_cur_floor]) begin
                  w_state_next              = ST_DOOR;
                  w_clear_mask[w_cur_floor] = 1'b1;
                  w_door_start              = 1'b1;
               end else if (|r_pending) begin
                  w_state_next = ST_DISPATCH;
               end
            end
            ST_DISPATCH: if (w_handshake) w_state_next = ST_TRAVEL;
            ST_TRAVEL: begin
               if (bus.car_arrived) begin
                  w_state_next                = ST_DOOR;
                  w_clear_mask[r_target_floor] = 1'b1;
                  w_call_mask[r_target_floor]  = 1'b0;
                  w_door_start                = 1'b1;
               end
            end
            ST_DOOR: begin
               // A call at the open floor is absorbed and keeps the door open longer.
               if (bus.call_req[w_cur_floor]) begin
                  w_door_restart           = 1'b1;
                  w_call_mask[w_cur_floor] = 1'b0;
               end else if (w_door_done) begin
                  w_state_next = ST_IDLE;
               end
            end
            ST_HALT: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_tv_next     = (w_state_next == ST_DISPATCH);
      w_dh_next     = (w_state_next == ST_DOOR) || (w_state_next == ST_HALT);
      w_busy_next   = (w_state_next != ST_IDLE);
      w_load_target = (r_state == ST_IDLE) && (w_state_next == ST_DISPATCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_target_valid <= 1'b0;
         r_target_floor <= '0;
         r_dir_up       <= DIR_UP;
         r_door_hold    <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_target_valid <= w_tv_next;
         r_door_hold    <= w_dh_next;
         r_busy         <= w_busy_next;
         if (w_load_target) begin
            r_target_floor <= w_sel_floor;
            r_dir_up       <= w_sel_dir;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pending <= '0;
      else     r_pending <= (r_pending | (bus.call_req & w_call_mask)) & ~w_clear_mask;
   end

   assign w_door_clear = (r_state == ST_HALT);
   assign w_door_run   = (r_state == ST_DOOR);

   elevator_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (w_door_start),
      .restart (w_door_restart),
      .clear   (w_door_clear),
      .hold    (w_door_run),
      .done    (w_door_done)
   );

`ifdef SCHED_STATS_EN
   logic [15:0] r_served_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_served_count <= 16'd0;
      end else if ((w_state_next == ST_DOOR) && (r_state != ST_DOOR) &&
                   (r_served_count != 16'hFFFF)) begin
         r_served_count <= r_served_count + 16'd1;
      end
   end

   assign bus.served_count = r_served_count;
`endif

   assign bus.target_valid = r_target_valid;
   assign bus.target_floor = r_target_floor;
   assign bus.pending      = r_pending;
   assign bus.dir_up       = r_dir_up;
   assign bus.door_hold    = r_door_hold;
   assign bus.busy         = r_busy;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scenario bench for elevator_request_scheduler: expected targets are queued when calls
// are driven and compared when the scheduler offers them.
module tb_elevator_request_scheduler;
   import elevator_pkg::*;

   logic   clk;
   logic   rst;
   int     n_checks = 0;
   int     n_fail   = 0;
   floor_t exp_q[$];
   floor_t exp_f;

   elevator_request_scheduler_if #(.NUM_FLOORS(4)) bus();

   elevator_request_scheduler #(.NUM_FLOORS(4), .DOOR_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required end of test");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tv(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (bus.target_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic do_handshake(output bit ok, output floor_t got, output logic tv_after);
      wait_tv(20, ok);
      got = bus.target_floor;
      bus.target_ready = 1'b1;
      step();
      bus.target_ready = 1'b0;
      tv_after = bus.target_valid;
   endtask

   task automatic do_arrive(input floor_t f, input logic [3:0] call, output int n,
                            output logic [3:0] pend_after);
      step();
      bus.current_floor = f;
      bus.car_arrived   = 1'b1;
      bus.call_req      = call;
      step();
      bus.car_arrived = 1'b0;
      bus.call_req    = 4'b0000;
      pend_after      = bus.pending;
      n = 0;
      while (bus.door_hold === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      step();
      step();
      n_checks++; if (bus.target_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tv: got %b need 0", bus.target_valid); end
      n_checks++; if (bus.target_floor !== 2'd0) begin n_fail++; $display("FAIL reset_tf: got %0d need 0", bus.target_floor); end
      n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b need 0000", bus.pending); end
      n_checks++; if (bus.dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b need 1", bus.dir_up); end
      n_checks++; if (bus.door_hold !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b need 0", bus.door_hold); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      bit ok; floor_t got; logic tva; int n; logic [3:0] pend;
      bus.car_arrived = 1'b1;
      step();
      bus.car_arrived = 1'b0;
      n_checks++; if (bus.busy !== 1'b0 || bus.door_hold !== 1'b0) begin n_fail++; $display("FAIL stray_arrival: busy=%b door=%b need 0 0", bus.busy, bus.door_hold); end
      bus.current_floor = 2'd0;
      bus.call_req      = 4'b0100;
      exp_q.push_back(2'd2);
      step();
      bus.call_req = 4'b0000;
      n_checks++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL basic_pending: got %b need 0100", bus.pending); end
      n_checks++; if (bus.target_valid !== 1'b0) begin n_fail++; $display("FAIL basic_tv_c1: got %b need 0", bus.target_valid); end
      step();
      n_checks++; if (bus.target_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tv_c2: got %b need 1", bus.target_valid); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b need 1", bus.busy); end
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_offer_timeout: target_valid=%b need 1", bus.target_valid); end
      n_checks++; if (got !== exp_f) begin n_fail++; $display("FAIL basic_target: got %0d need %0d", got, exp_f); end
      n_checks++; if (tva !== 1'b0) begin n_fail++; $display("FAIL basic_tv_drop: got %b need 0", tva); end
      do_arrive(2'd2, 4'b0100, n, pend);
      n_checks++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL basic_arrive_pending: got %b need 0000", pend); end
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL basic_door_len: got %0d need 8", n); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy=%b need 0", bus.busy); end
   endtask

   task automatic test_scan();
      bit ok; floor_t got; logic tva; int n; logic [3:0] pend;
      bus.current_floor = 2'd1;
      bus.call_req      = 4'b1001;
      exp_q.push_back(2'd3);
      step();
      bus.call_req = 4'b0000;
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (!ok || got !== exp_f) begin n_fail++; $display("FAIL scan_up_target: ok=%b got %0d need %0d", ok, got, exp_f); end
      n_checks++; if (bus.dir_up !== 1'b1) begin n_fail++; $display("FAIL scan_up_dir: got %b need 1", bus.dir_up); end
      exp_q.push_back(2'd0);
      do_arrive(2'd3, 4'b0000, n, pend);
      n_checks++; if (pend !== 4'b0001) begin n_fail++; $display("FAIL scan_pending: got %b need 0001", pend); end
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL scan_door_len: got %0d need 8", n); end
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (!ok || got !== exp_f) begin n_fail++; $display("FAIL scan_down_target: ok=%b got %0d need %0d", ok, got, exp_f); end
      n_checks++; if (bus.dir_up !== 1'b0) begin n_fail++; $display("FAIL scan_down_dir: got %b need 0", bus.dir_up); end
      do_arrive(2'd0, 4'b0000, n, pend);
      n_checks++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL scan_final_pending: got %b need 0000", pend); end
   endtask

   task automatic test_hold_stable();
      bit ok; floor_t got; logic tva; int n; logic [3:0] pend;
      bus.call_req = 4'b0010;
      exp_q.push_back(2'd1);
      step();
      bus.call_req = 4'b0000;
      wait_tv(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_offer_timeout: target_valid=%b need 1", bus.target_valid); end
      for (int k = 0; k < 5; k++) begin
         if (k == 1) bus.call_req = 4'b1000;
         step();
         bus.call_req = 4'b0000;
         n_checks++; if (bus.target_valid !== 1'b1 || bus.target_floor !== exp_q[0]) begin n_fail++; $display("FAIL hold_stable_%0d: tv=%b tf=%0d need 1 %0d", k, bus.target_valid, bus.target_floor, exp_q[0]); end
      end
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (got !== exp_f) begin n_fail++; $display("FAIL hold_target: got %0d need %0d", got, exp_f); end
      n_checks++; if (bus.pending !== 4'b1010) begin n_fail++; $display("FAIL hold_pending: got %b need 1010", bus.pending); end
      exp_q.push_back(2'd3);
      do_arrive(2'd1, 4'b0000, n, pend);
      n_checks++; if (pend !== 4'b1000) begin n_fail++; $display("FAIL hold_arrive_pending: got %b need 1000", pend); end
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (!ok || got !== exp_f) begin n_fail++; $display("FAIL hold_next_target: ok=%b got %0d need %0d", ok, got, exp_f); end
      n_checks++; if (bus.dir_up !== 1'b1) begin n_fail++; $display("FAIL hold_next_dir: got %b need 1", bus.dir_up); end
      do_arrive(2'd3, 4'b0000, n, pend);
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL hold_door_len: got %0d need 8", n); end
   endtask

   task automatic test_door_restart();
      int n;
      bus.current_floor = 2'd2;
      bus.call_req      = 4'b0100;
      step();
      bus.call_req = 4'b0000;
      step();
      n_checks++; if (bus.door_hold !== 1'b1 || bus.pending !== 4'b0000) begin n_fail++; $display("FAIL door_entry: door=%b pending=%b need 1 0000", bus.door_hold, bus.pending); end
      repeat (4) step();
      n_checks++; if (bus.door_hold !== 1'b1) begin n_fail++; $display("FAIL door_cycle5: got %b need 1", bus.door_hold); end
      bus.call_req = 4'b0100;
      step();
      bus.call_req = 4'b0000;
      n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL door_call_pending: got %b need 0000", bus.pending); end
      n = 0;
      while (bus.door_hold === 1'b1 && n < 40) begin
         n++;
         step();
      end
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL door_restart_len: got %0d need 8", n); end
   endtask

   task automatic test_emergency();
      bit ok; floor_t got; logic tva;
      bus.current_floor = 2'd2;
      bus.call_req      = 4'b1010;
      exp_q.push_back(2'd3);
      step();
      bus.call_req = 4'b0000;
      do_handshake(ok, got, tva);
      exp_f = exp_q.pop_front();
      n_checks++; if (!ok || got !== exp_f || tva !== 1'b0) begin n_fail++; $display("FAIL estop_setup: ok=%b tf=%0d tv=%b need 1 %0d 0", ok, got, tva, exp_f); end
      bus.emergency_stop = 1'b1;
      step();
      n_checks++; if (bus.door_hold !== 1'b1 || bus.target_valid !== 1'b0) begin n_fail++; $display("FAIL estop_halt: door=%b tv=%b need 1 0", bus.door_hold, bus.target_valid); end
      n_checks++; if (bus.pending !== 4'b1010) begin n_fail++; $display("FAIL estop_pending: got %b need 1010", bus.pending); end
      step();
      n_checks++; if (bus.door_hold !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL estop_hold2: door=%b busy=%b need 1 1", bus.door_hold, bus.busy); end
      bus.emergency_stop = 1'b0;
      step();
      n_checks++; if (bus.busy !== 1'b0 || bus.door_hold !== 1'b0) begin n_fail++; $display("FAIL estop_idle: busy=%b door=%b need 0 0", bus.busy, bus.door_hold); end
      exp_q.push_back(2'd3);
      step();
      n_checks++; if (bus.target_valid !== 1'b1 || bus.target_floor !== exp_q[0]) begin n_fail++; $display("FAIL estop_redispatch: tv=%b tf=%0d need 1 %0d", bus.target_valid, bus.target_floor, exp_q[0]); end
   endtask

   task automatic test_reset_mid_dispatch();
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      n_checks++; if (bus.target_valid !== 1'b0 || bus.target_floor !== 2'd0) begin n_fail++; $display("FAIL async_rst_target: tv=%b tf=%0d need 0 0", bus.target_valid, bus.target_floor); end
      n_checks++; if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_state: pending=%b busy=%b need 0000 0", bus.pending, bus.busy); end
      n_checks++; if (bus.dir_up !== 1'b1 || bus.door_hold !== 1'b0) begin n_fail++; $display("FAIL async_rst_dir_door: dir=%b door=%b need 1 0", bus.dir_up, bus.door_hold); end
      step();
      rst = 1'b0;
      repeat (3) step();
      n_checks++; if (bus.busy !== 1'b0 || bus.target_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard: busy=%b tv=%b need 0 0", bus.busy, bus.target_valid); end
   endtask

   initial begin
      rst                = 1'b1;
      bus.emergency_stop = 1'b0;
      bus.call_req       = 4'b0000;
      bus.current_floor  = 2'd0;
      bus.car_arrived    = 1'b0;
      bus.target_ready   = 1'b0;
      test_reset();
      test_basic();
      test_scan();
      test_hold_stable();
      test_door_restart();
      test_emergency();
      test_reset_mid_dispatch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors; floor index width is clog2(NUM_FLOORS).
REQ-002 Parameter DOOR_CYCLES, default 8, number of cycles door_hold stays asserted per stop; legal range 1..255.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 emergency_stop  in  1  level; forces HALT while high.
REQ-006 call_req  in  NUM_FLOORS  one bit per floor, single-cycle pulses; multiple bits may be set together.
REQ-007 current_floor  in  2  car position reported by the car controller.
REQ-008 car_arrived  in  1  one-cycle pulse when the car reaches the issued target.
REQ-009 target_ready  in  1  car controller accepts target_floor.
REQ-010 target_valid  out  1  target_floor offered.
REQ-011 target_floor  out  2  floor to serve.
REQ-012 pending  out  NUM_FLOORS  latched outstanding requests.
REQ-013 dir_up  out  1  current sweep direction; 1 = up.
REQ-014 door_hold  out  1  door must stay open.
REQ-015 busy  out  1  state is not IDLE.

Function
REQ-016 States: IDLE, DISPATCH, TRAVEL, DOOR, HALT; all outputs registered.
REQ-017 call_req bit k high in cycle N shall set pending[k] in cycle N+1, in every state including HALT.
REQ-018 IDLE: if pending[current_floor] is set, go to DOOR and clear that bit; else if pending is nonzero, go to DISPATCH; else remain.
REQ-019 Selection (SCAN), computed on entry to DISPATCH:
- dir_up=1: pick the lowest pending floor above current_floor.
- If none exists, toggle dir_up and pick the highest pending floor below current_floor.
- Down direction is symmetric.
REQ-020 A call pulse in cycle N from IDLE with nothing pending shall give target_valid=1 in cycle N+2.
REQ-021 DISPATCH: target_valid=1; target_floor is held stable until target_valid and target_ready are both high in the same cycle, then the block goes to TRAVEL and drops target_valid the next cycle.
REQ-022 TRAVEL: wait for car_arrived, then clear pending[target_floor], enter DOOR, and assert door_hold.
REQ-023 DOOR: door_hold=1 for exactly DOOR_CYCLES cycles, then go to IDLE.
REQ-024 In DOOR, a call_req for current_floor shall not set pending and shall restart the door count.
REQ-025 In TRAVEL, a call for target_floor in the same cycle as car_arrived shall not set pending.
REQ-026 car_arrived outside TRAVEL shall be ignored.
REQ-027 emergency_stop high in any state: next state is HALT, with target_valid=0 and door_hold=1. Pending is retained; a pending handshake is abandoned.
REQ-028 HALT exits to IDLE one cycle after emergency_stop falls; the door count is reset.
REQ-029 A current_floor value of NUM_FLOORS or above shall be treated as floor NUM_FLOORS-1.

Reset
REQ-030 While rst is high: state=IDLE, pending=0, dir_up=1, target_valid=0, target_floor=0, door_hold=0, busy=0, door counter=0. Reset mid-operation discards all requests.

Configuration
REQ-031 SCHED_STATS_EN defined: adds output served_count[15:0], incremented on each entry to DOOR, saturating at 0xFFFF, reset to 0.
REQ-032 SCHED_STATS_EN undefined: the port and the counter do not exist; all other behaviour is identical.

Structure
REQ-033 The shared package elevator_pkg holds:
- the state encoding;
- NUM_FLOORS_DEFAULT;
- the floor index type;
- the DIR_UP/DIR_DOWN constants.
REQ-034 Door timing is a sub-module elevator_door_timer with ports start, restart, clear, hold, and done.

Verification
REQ-035 Reset, current_floor=0, call_req=4'b0100 at cycle 0 -> target_valid=1 with target_floor=2 at cycle 2; target_ready=1 -> TRAVEL; car_arrived -> door_hold for 8 cycles, pending=0.
REQ-036 current_floor=1, dir_up=1, pending=4'b1001 -> target_floor=3; after serving, current_floor=3 -> dir_up=0 and target_floor=0.
REQ-037 target_ready held low for 5 cycles in DISPATCH with a new call at floor 3 -> target_floor unchanged until the handshake completes.
REQ-038 In DOOR at floor 2, call_req=4'b0100 in door cycle 5 -> pending[2] stays 0 and door_hold lasts 8 more cycles.
REQ-039 emergency_stop pulsed in TRAVEL with pending=4'b1010 -> HALT, door_hold=1, target_valid=0, pending still 4'b1010; after release -> IDLE, then DISPATCH.
REQ-040 rst asserted mid-DISPATCH -> all outputs at reset values immediately, without waiting for a clock edge.
